// File: rtl/ysyx_22040127_rr_encoder_pkg.sv
// ysyx_22040127_rr_encoder_pkg
//  Shared constants and helpers for the round-robin request encoder slice.
//  Contents:
//    RRENC_N_DEFAULT  default number of request lines
//    rrenc_idx_w()    binary index width for N lines ($clog2, never below 1)
//  The build option YSYX_22040127_RRENC_FIXED_PRIO_EN is the macro that
//  switches the encoder from round-robin to fixed lowest-index priority.
package ysyx_22040127_rr_encoder_pkg;

  localparam int RRENC_N_DEFAULT = 8;

  // Index width for n request lines. A floor of 1 keeps the index port
  // legal even for degenerate sizes.
  function automatic int rrenc_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ysyx_22040127_rr_encoder_if.sv
// ysyx_22040127_rr_encoder_if
//  Valid/ready issue channel from the encoder to its single consumer.
//  Signals:
//    out_valid   producer -> consumer  slot holds a request
//    out_ready   consumer -> producer  consumer accepts this cycle
//    out_idx     producer -> consumer  binary index of the issued request
//    out_onehot  producer -> consumer  one-hot copy of out_idx (0 when idle)
//  Modports: master (encoder side), slave (consumer side).
interface ysyx_22040127_rr_encoder_if
  import ysyx_22040127_rr_encoder_pkg::*;
#(
  parameter int N = RRENC_N_DEFAULT
);
  localparam int W = rrenc_idx_w(N);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;

  modport master (
    output out_valid,
    output out_idx,
    output out_onehot,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_onehot,
    output out_ready
  );
endinterface

// File: rtl/ysyx_22040127_rr_encoder_pick.sv
// ysyx_22040127_rr_pick
//  Combinational round-robin selector. Finds the first set bit of pending
//  starting at ptr and wrapping through N-1 -> 0.
//  Ports:
//    pending  in   N  candidate set
//    ptr      in   W  first index to consider
//    found    out  1  pending is non-zero
//    idx      out  W  selected index (0 when !found)
//    onehot   out  N  one-hot of idx (0 when !found)
module ysyx_22040127_rr_pick
  import ysyx_22040127_rr_encoder_pkg::*;
#(
  parameter int N = RRENC_N_DEFAULT,
  localparam int W = rrenc_idx_w(N)
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  // Lower copy only keeps bits at or above ptr; the upper copy holds the
  // full set, so a plain LSB-first search over the doubled vector visits
  // ptr..N-1 first and then wraps to 0..ptr-1.
  logic [N-1:0]   at_or_above_ptr;
  logic [2*N-1:0] search_vec;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_keep
      assign at_or_above_ptr[gi] = (gi >= int'(ptr));
    end
  endgenerate

  assign search_vec = {pending, pending & at_or_above_ptr};

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && search_vec[i]) begin
        found = 1'b1;
        // Hits in the upper copy fold back onto the real index range,
        // so indices >= N never leave this block.
        idx   = (i >= N) ? W'(i - N) : W'(i);
      end
    end
  end

  assign onehot = found ? (N'(1) << idx) : '0;

endmodule

// File: rtl/ysyx_22040127_rr_encoder.sv
// ysyx_22040127_rr_encoder
//  Collects request pulses on N lines into a pending set and issues them
//  one at a time, round-robin fair, over a valid/ready channel.
//  Ports:
//    clk          in   1  clock, rising edge
//    rst          in   1  asynchronous active-high reset
//    req_i        in   N  request pulses; bit k sets pending[k]
//    out_if       master modport: out_valid/out_ready/out_idx/out_onehot
//    pend_o       out  N  pending set (excludes the request in the slot)
//    merge_o      out  1  sticky: a request hit an already-pending bit
//    merge_clr_i  in   1  clears merge_o; a same-cycle set wins
//  Build option:
//    YSYX_22040127_RRENC_FIXED_PRIO_EN  defined -> lowest pending index
//    always wins (pointer removed, tied to 0). Undefined -> round-robin.
module ysyx_22040127_rr_encoder
  import ysyx_22040127_rr_encoder_pkg::*;
#(
  parameter int N = RRENC_N_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N-1:0]                     req_i,
  ysyx_22040127_rr_encoder_if.master       out_if,
  output logic [N-1:0]                     pend_o,
  output logic                             merge_o,
  input  logic                             merge_clr_i
);

  localparam int W = rrenc_idx_w(N);

  logic [N-1:0] pending_reg;
  logic [N-1:0] pending_next;
  logic         valid_reg;
  logic [W-1:0] idx_reg;
  logic [N-1:0] onehot_reg;
  logic         merge_reg;
  logic         merge_next;

  logic [W-1:0] ptr_cur;
  logic         slot_free;
  logic         pick_found;
  logic         pick_valid;
  logic [W-1:0] pick_idx;
  logic [N-1:0] pick_onehot;
  logic [N-1:0] pick_mask;
  logic         merge_set;

  // The slot can take a new request when empty or being drained this cycle.
  assign slot_free  = !valid_reg || out_if.out_ready;
  assign pick_valid = slot_free && pick_found;
  assign pick_mask  = pick_valid ? pick_onehot : '0;

  ysyx_22040127_rr_pick #(
    .N (N)
  ) u_pick (
    .pending (pending_reg),
    .ptr     (ptr_cur),
    .found   (pick_found),
    .idx     (pick_idx),
    .onehot  (pick_onehot)
  );

`ifdef YSYX_22040127_RRENC_FIXED_PRIO_EN
  assign ptr_cur = '0;
`else
  logic [W-1:0] ptr_reg;
  logic [W-1:0] ptr_next;

  // Next search starts just after the winner, wrapping N-1 -> 0 explicitly
  // so non-power-of-two N never produces an out-of-range pointer.
  always_comb begin
    ptr_next = ptr_reg;
    if (pick_valid) begin
      ptr_next = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr_cur = ptr_reg;
`endif

  // A new pulse re-arms a line even in the cycle its previous request is
  // picked, so nothing is lost when request and issue coincide.
  assign pending_next = (pending_reg & ~pick_mask) | req_i;

  // Only hits on bits that stay pending count as merges; re-requesting the
  // line being picked or sitting in the slot queues a fresh issue instead.
  assign merge_set = |(req_i & pending_reg & ~pick_mask);

  always_comb begin
    merge_next = merge_reg;
    if (merge_set) begin
      merge_next = 1'b1;
    end else if (merge_clr_i) begin
      merge_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
      merge_reg   <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      merge_reg   <= merge_next;
    end
  end

  // Output slot: load on a pick, empty when free with nothing to issue,
  // otherwise hold steady for the stalled consumer. idx deliberately keeps
  // its last value when the slot empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg  <= 1'b0;
      idx_reg    <= '0;
      onehot_reg <= '0;
    end else if (pick_valid) begin
      valid_reg  <= 1'b1;
      idx_reg    <= pick_idx;
      onehot_reg <= pick_onehot;
    end else if (slot_free) begin
      valid_reg  <= 1'b0;
      onehot_reg <= '0;
    end
  end

  assign out_if.out_valid  = valid_reg;
  assign out_if.out_idx    = idx_reg;
  assign out_if.out_onehot = onehot_reg;
  assign pend_o            = pending_reg;
  assign merge_o           = merge_reg;

endmodule
